// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched : multiply/divide sequencer for the EX stage of the MIPS pipeline.
//
// Runs MULT/MULTU/DIV/DIVU iteratively on operand magnitudes, applies the
// sign fix-up in a final FIX cycle and owns the architectural HI/LO
// registers. MTHI/MTLO write HI/LO in a single edge without going busy.
// A combinational stall request holds any HI/LO-using instruction in ID
// while the unit is (or is about to become) busy.
//
// Optional feature macro: MD_SCHED_FAST_MUL_EN
//   defined   : MULT/MULTU use a combinational multiplier (IDLE -> FIX).
//   undefined : MULT/MULTU use the iterative shift-add path.
//
// Ports:
//   clk         - clock, rising-edge active
//   rst_n       - asynchronous active-low reset
//   md_start    - EX-stage instruction is a mul/div/mthi/mtlo op
//   md_op       - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO (6/7 ignored)
//   rs_val      - dividend / multiplicand / MTHI-MTLO source
//   rt_val      - divisor / multiplier
//   id_use_hilo - ID-stage instruction touches HI/LO
//   busy        - arithmetic operation in progress (RUN or FIX)
//   stall       - freeze PC and IF/ID, bubble into ID/EX
//   hi, lo      - HI / LO registers
// ---------------------------------------------------------------------------
module md_sched #(
    parameter int ITER_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        id_use_hilo,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Two's-complement negation when neg is set.
    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    logic [1:0]    state_r,    state_s;
    logic [CW-1:0] cnt_r,      cnt_s;
    // Multiply: [63:32] partial sum, [31:0] remaining multiplier bits.
    // Divide:   [63:32] partial remainder, [31:0] dividend shifting into quotient.
    logic [63:0]   acc_r,      acc_s;
    logic [31:0]   opnd_r,     opnd_s;     // multiplicand or divisor magnitude
    logic          op_div_r,   op_div_s;
    logic          neg_res_r,  neg_res_s;  // product / quotient sign
    logic          neg_rem_r,  neg_rem_s;  // remainder sign (dividend sign)
    logic          div_zero_r, div_zero_s;
    logic [31:0]   hi_r,       hi_s;
    logic [31:0]   lo_r,       lo_s;
    logic          busy_r,     busy_s;

    logic          is_arith_s;
    logic          is_signed_s;
    logic          is_div_op_s;
    logic [31:0]   abs_rs_s;
    logic [31:0]   abs_rt_s;
    logic [32:0]   mul_add_s;
    logic [63:0]   mul_step_s;
    logic [32:0]   rem_sh_s;
    logic [32:0]   diff_s;
    logic [63:0]   div_step_s;
    logic [63:0]   mul_fix_s;
    logic [31:0]   quo_fix_s;
    logic [31:0]   rem_fix_s;
`ifdef MD_SCHED_FAST_MUL_EN
    logic [63:0]   fast_prod_s;
`endif

    assign is_arith_s  = md_start & ~md_op[2];
    assign is_signed_s = ~md_op[0];
    assign is_div_op_s = md_op[1];
    assign abs_rs_s    = cond_neg32(rs_val, is_signed_s & rs_val[31]);
    assign abs_rt_s    = cond_neg32(rt_val, is_signed_s & rt_val[31]);

    // Shift-add: add multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign mul_add_s  = {1'b0, acc_r[63:32]} + {1'b0, (acc_r[0] ? opnd_r : 32'd0)};
    assign mul_step_s = {mul_add_s, acc_r[31:1]};

    // Restoring divide: bring in the next dividend bit, trial-subtract,
    // keep the difference only if it did not go negative.
    assign rem_sh_s   = {acc_r[63:32], acc_r[31]};
    assign diff_s     = rem_sh_s - {1'b0, opnd_r};
    assign div_step_s = diff_s[32] ? {rem_sh_s[31:0], acc_r[30:0], 1'b0}
                                   : {diff_s[31:0],   acc_r[30:0], 1'b1};

    assign mul_fix_s = cond_neg64(acc_r, neg_res_r);
    assign quo_fix_s = cond_neg32(acc_r[31:0], neg_res_r);
    assign rem_fix_s = cond_neg32(acc_r[63:32], neg_rem_r);

`ifdef MD_SCHED_FAST_MUL_EN
    assign fast_prod_s = {32'd0, abs_rs_s} * {32'd0, abs_rt_s};
`endif

    // Next-state and datapath update logic for the sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        acc_s      = acc_r;
        opnd_s     = opnd_r;
        op_div_s   = op_div_r;
        neg_res_s  = neg_res_r;
        neg_rem_s  = neg_rem_r;
        div_zero_s = div_zero_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        case (state_r)
            IDLE: begin
                if (is_arith_s) begin
                    cnt_s      = '0;
                    op_div_s   = is_div_op_s;
                    neg_res_s  = is_signed_s & (rs_val[31] ^ rt_val[31]);
                    neg_rem_s  = is_signed_s & is_div_op_s & rs_val[31];
                    div_zero_s = is_div_op_s & (rt_val == 32'd0);
                    if (is_div_op_s) begin
                        opnd_s  = abs_rt_s;
                        acc_s   = {32'd0, abs_rs_s};
                        state_s = RUN;
                    end else begin
`ifdef MD_SCHED_FAST_MUL_EN
                        opnd_s  = abs_rs_s;
                        acc_s   = fast_prod_s;
                        state_s = FIX;
`else
                        opnd_s  = abs_rs_s;
                        acc_s   = {32'd0, abs_rt_s};
                        state_s = RUN;
`endif
                    end
                end else if (md_start && (md_op == 3'd4)) begin
                    hi_s = rs_val;
                end else if (md_start && (md_op == 3'd5)) begin
                    lo_s = rs_val;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = op_div_r ? div_step_s : mul_step_s;
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    state_s = FIX;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            FIX: begin
                if (op_div_r) begin
                    hi_s = rem_fix_s;
                    lo_s = div_zero_r ? 32'hFFFF_FFFF : quo_fix_s;
                end else begin
                    hi_s = mul_fix_s[63:32];
                    lo_s = mul_fix_s[31:0];
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Sequencer state and HI/LO registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            acc_r      <= 64'd0;
            opnd_r     <= 32'd0;
            op_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            opnd_r     <= opnd_s;
            op_div_r   <= op_div_s;
            neg_res_r  <= neg_res_s;
            neg_rem_r  <= neg_rem_s;
            div_zero_r <= div_zero_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            busy_r     <= busy_s;
        end
    end

    // Stall also covers the start cycle itself, before busy rises.
    assign stall = id_use_hilo & (busy_r | is_arith_s);
    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule
